atm_txn_ctrl: RTL and testbench

Session and transaction controller downstream of the card-handling stage. It consumes the per-card balance and password-check result from that stage, runs the PIN-retry policy, and executes inquiry, withdrawal, deposit and eject requests against the loaded balance. It returns `updated_balance` with a one-cycle `op_done` pulse so card handling can write the new balance back to its store.

---
 rtl/atm_pkg.sv | 35 +++
 rtl/atm_txn_ctrl_if.sv | 33 +++
 rtl/atm_txn_ctrl_session_timer.sv | 29 ++
 rtl/atm_txn_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_atm_txn_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared encodings for the ATM transaction controller: op selects, status codes,
// FSM states and the default balance width.
package atm_pkg;
    localparam int unsigned BALANCE_W_DEF = 20;

    typedef enum logic [1:0] {
        OP_INQUIRY  = 2'b00,
        OP_WITHDRAW = 2'b01,
        OP_DEPOSIT  = 2'b10,
        OP_EJECT    = 2'b11
    } op_sel_e;

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_FUNDS    = 3'd1;
    localparam logic [2:0] ERR_LIMIT    = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_PIN      = 3'd4;
    localparam logic [2:0] ERR_RETAINED = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AUTH   = 3'd1,
        S_MENU   = 3'd2,
        S_EXEC   = 3'd3,
        S_DONE   = 3'd4,
        S_EJECT  = 3'd5,
        S_RETAIN = 3'd6
    } state_e;

    // States in which the controller is waiting on the customer and may time out.
    function automatic logic is_waiting(input state_e s);
        return (s == S_AUTH) || (s == S_MENU);
    endfunction
endpackage

// File: rtl/atm_txn_ctrl_if.sv
// Signal bundle between the card-handling stage (master) and the transaction
// controller (slave).
interface atm_txn_ctrl_if #(
    parameter int unsigned BW = atm_pkg::BALANCE_W_DEF
);
    logic          card_in;
    logic          psw_en;
    logic          wrong_psw;
    logic [BW-1:0] balance;
    logic          op_valid;
    logic [1:0]    op_sel;
    logic [BW-1:0] amount;
    logic [BW-1:0] updated_balance;
    logic          op_done;
    logic          dispense;
    logic [BW-1:0] dispense_amount;
    logic [2:0]    err;
    logic          card_eject;
    logic          card_retain;
    logic          session_active;

    modport master (
        output card_in, psw_en, wrong_psw, balance, op_valid, op_sel, amount,
        input  updated_balance, op_done, dispense, dispense_amount, err,
               card_eject, card_retain, session_active
    );

    modport slave (
        input  card_in, psw_en, wrong_psw, balance, op_valid, op_sel, amount,
        output updated_balance, op_done, dispense, dispense_amount, err,
               card_eject, card_retain, session_active
    );
endinterface

// File: rtl/atm_txn_ctrl_session_timer.sv
// Idle counter for the customer-wait states: runs while enabled, restarts on a
// customer strobe, flags expiry on its last count.
module session_timer #(
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int unsigned CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [CW-1:0] LAST = CW'(timeout_cycles - 1);

    logic [CW-1:0] cnt_q;

    assign expire_o = en_i && (cnt_q == LAST);

    // Leaving the wait states drops en_i, which also parks the count at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en_i || clr_i || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM session/transaction controller: PIN-retry policy, then inquiry, withdraw,
// deposit and eject requests against the balance captured at card insertion.
module atm_txn_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned              balance_width  = BALANCE_W_DEF,
    parameter int unsigned              max_tries      = 3,
    parameter int unsigned              timeout_cycles = 1024,
    parameter logic [balance_width-1:0] session_limit  = balance_width'(5000)
) (
    input  logic          clk,
    input  logic          rst,
    atm_txn_ctrl_if.slave bus
);
    localparam int unsigned   TW       = $clog2(max_tries + 1);
    localparam logic [TW-1:0] LAST_TRY = TW'(max_tries - 1);

    typedef logic [balance_width-1:0] bal_t;

    state_e        state_q;
    op_sel_e       op_q;
    bal_t          bal_q, acc_q, amt_q, upd_bal_q, disp_amt_q;
    logic [TW-1:0] tries_q;
    logic [2:0]    err_q;
    logic          card_q, op_done_q, dispense_q, eject_q, retain_q, active_q;

    logic                 timer_en, timer_clr, timer_expire;
    logic [balance_width:0] dep_sum, acc_sum;
    bal_t                 bal_d, acc_d;
    logic [2:0]           err_d;
    logic                 disp_d;

    assign timer_en  = is_waiting(state_q);
    assign timer_clr = ((state_q == S_AUTH) && bus.psw_en) ||
                       ((state_q == S_MENU) && bus.op_valid);

    session_timer #(.timeout_cycles(timeout_cycles)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en_i     (timer_en),
        .clr_i    (timer_clr),
        .expire_o (timer_expire)
    );

    // Outcome of the latched request; only committed on the EXEC -> DONE edge.
    always_comb begin
        dep_sum = {1'b0, bal_q} + {1'b0, amt_q};
        acc_sum = {1'b0, acc_q} + {1'b0, amt_q};
        bal_d   = bal_q;
        acc_d   = acc_q;
        err_d   = ERR_OK;
        disp_d  = 1'b0;
        case (op_q)
            OP_WITHDRAW: begin
                if (amt_q > bal_q) begin
                    err_d = ERR_FUNDS;
                end else if (acc_sum > {1'b0, session_limit}) begin
                    err_d = ERR_LIMIT;
                end else begin
                    bal_d  = bal_q - amt_q;
                    acc_d  = acc_sum[balance_width-1:0];
                    disp_d = (amt_q != '0);
                end
            end
            OP_DEPOSIT: begin
                if (dep_sum[balance_width]) err_d = ERR_OVERFLOW;
                else                        bal_d = dep_sum[balance_width-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_INQUIRY;
            bal_q      <= '0;
            acc_q      <= '0;
            amt_q      <= '0;
            upd_bal_q  <= '0;
            disp_amt_q <= '0;
            tries_q    <= '0;
            err_q      <= ERR_OK;
            card_q     <= 1'b0;
            op_done_q  <= 1'b0;
            dispense_q <= 1'b0;
            eject_q    <= 1'b0;
            retain_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            card_q     <= bus.card_in;
            op_done_q  <= 1'b0;
            dispense_q <= 1'b0;
            eject_q    <= 1'b0;
            retain_q   <= 1'b0;
            // Card removal outranks everything: no pulses, pending result dropped.
            if ((state_q != S_IDLE) && !bus.card_in) begin
                state_q  <= S_IDLE;
                active_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.card_in && !card_q) begin
                            state_q  <= S_AUTH;
                            active_q <= 1'b1;
                            tries_q  <= '0;
                            acc_q    <= '0;
                            err_q    <= ERR_OK;
                            bal_q    <= bus.balance;
                        end
                    end
                    S_AUTH: begin
                        if (bus.psw_en) begin
                            if (!bus.wrong_psw) begin
                                state_q <= S_MENU;
                            end else begin
                                tries_q <= tries_q + TW'(1);
                                if (tries_q == LAST_TRY) begin
                                    state_q  <= S_RETAIN;
                                    active_q <= 1'b0;
                                    retain_q <= 1'b1;
                                    err_q    <= ERR_RETAINED;
                                end else begin
                                    err_q <= ERR_PIN;
                                end
                            end
                        end else if (timer_expire) begin
                            state_q  <= S_EJECT;
                            active_q <= 1'b0;
                            eject_q  <= 1'b1;
                            err_q    <= ERR_TIMEOUT;
                        end
                    end
                    S_MENU: begin
                        if (bus.op_valid) begin
                            if (bus.op_sel == OP_EJECT) begin
                                state_q  <= S_EJECT;
                                active_q <= 1'b0;
                                eject_q  <= 1'b1;
                                err_q    <= ERR_OK;
                            end else begin
                                state_q <= S_EXEC;
                                op_q    <= op_sel_e'(bus.op_sel);
                                amt_q   <= bus.amount;
                            end
                        end else if (timer_expire) begin
                            state_q  <= S_EJECT;
                            active_q <= 1'b0;
                            eject_q  <= 1'b1;
                            err_q    <= ERR_TIMEOUT;
                        end
                    end
                    S_EXEC: begin
                        state_q    <= S_DONE;
                        bal_q      <= bal_d;
                        acc_q      <= acc_d;
                        err_q      <= err_d;
                        upd_bal_q  <= bal_d;
                        op_done_q  <= 1'b1;
                        dispense_q <= disp_d;
                        if (disp_d) disp_amt_q <= amt_q;
                    end
                    S_DONE:            state_q <= S_MENU;
                    S_EJECT, S_RETAIN: state_q <= S_IDLE;
                    default: begin
                        state_q  <= S_IDLE;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.updated_balance = upd_bal_q;
    assign bus.op_done         = op_done_q;
    assign bus.dispense        = dispense_q;
    assign bus.dispense_amount = disp_amt_q;
    assign bus.err             = err_q;
    assign bus.card_eject      = eject_q;
    assign bus.card_retain     = retain_q;
    assign bus.session_active  = active_q;
endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Bench for atm_txn_ctrl: directed scenarios plus randomized sessions, checked
// every cycle against a session-level behavioural model.
module tb_atm_txn_ctrl;
    localparam int     BW   = 20;
    localparam int     MAXT = 3;
    localparam int     TO   = 1024;
    localparam longint LIM  = 5000;
    localparam longint BMAX = (longint'(1) << BW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    atm_txn_ctrl_if #(.BW(BW)) bus ();

    atm_txn_ctrl #(
        .balance_width  (BW),
        .max_tries      (MAXT),
        .timeout_cycles (TO),
        .session_limit  (20'd5000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: session flags, pending-request countdown and precomputed result.
    bit     m_prev, m_sess, m_term, m_authed;
    int     m_tries, m_idle, m_pend;
    longint m_bal, m_acc;
    longint r_bal, r_acc, r_amt;
    int     r_err;
    bit     r_disp;
    bit     e_done, e_disp, e_eject, e_retain, e_active;
    longint e_upd, e_damt;
    int     e_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_sess = 0; m_term = 0; m_authed = 0;
        m_tries = 0; m_idle = 0; m_pend = 0; m_bal = 0; m_acc = 0;
        e_done = 0; e_disp = 0; e_eject = 0; e_retain = 0; e_active = 0;
        e_upd = 0; e_damt = 0; e_err = 0;
    endtask

    task automatic end_session(input int code, input bit retain);
        e_err = code;
        if (retain) e_retain = 1; else e_eject = 1;
        m_sess = 0;
        m_term = 1;
    endtask

    task automatic wait_or_timeout();
        if (m_idle == TO - 1) end_session(6, 0);
        else m_idle++;
    endtask

    task automatic plan(input int sel, input longint amt);
        r_bal = m_bal; r_acc = m_acc; r_err = 0; r_disp = 0; r_amt = amt;
        if (sel == 1) begin
            if (amt > m_bal)            r_err = 1;
            else if (m_acc + amt > LIM) r_err = 2;
            else begin
                r_bal = m_bal - amt; r_acc = m_acc + amt; r_disp = (amt != 0);
            end
        end else if (sel == 2) begin
            if (m_bal + amt > BMAX) r_err = 3;
            else r_bal = m_bal + amt;
        end
    endtask

    // Advance the model across the coming rising edge using the inputs now driven.
    task automatic model_step();
        bit rise;
        if (rst) begin
            model_reset();
            return;
        end
        e_done = 0; e_disp = 0; e_eject = 0; e_retain = 0;
        rise   = bus.card_in && !m_prev;
        m_prev = bus.card_in;
        if (m_term) begin
            m_term = 0;
        end else if (!m_sess) begin
            if (rise) begin
                m_sess = 1; m_authed = 0; m_tries = 0; m_acc = 0; m_idle = 0;
                m_pend = 0; m_bal = longint'(bus.balance); e_err = 0;
            end
        end else if (!bus.card_in) begin
            m_sess = 0; m_pend = 0;
        end else if (m_pend == 2) begin
            m_pend = 1; m_bal = r_bal; m_acc = r_acc;
            e_err = r_err; e_upd = r_bal; e_done = 1; e_disp = r_disp;
            if (r_disp) e_damt = r_amt;
        end else if (m_pend == 1) begin
            m_pend = 0; m_idle = 0;
        end else if (!m_authed) begin
            if (bus.psw_en) begin
                m_idle = 0;
                if (!bus.wrong_psw) m_authed = 1;
                else begin
                    m_tries++;
                    if (m_tries == MAXT) end_session(5, 1);
                    else e_err = 4;
                end
            end else wait_or_timeout();
        end else begin
            if (bus.op_valid) begin
                m_idle = 0;
                if (bus.op_sel == 2'b11) end_session(0, 0);
                else begin
                    plan(int'(bus.op_sel), longint'(bus.amount));
                    m_pend = 2;
                end
            end else wait_or_timeout();
        end
        e_active = m_sess;
    endtask

    always @(negedge clk) begin
        chk("op_done",         32'(bus.op_done),         32'(e_done));
        chk("dispense",        32'(bus.dispense),        32'(e_disp));
        chk("card_eject",      32'(bus.card_eject),      32'(e_eject));
        chk("card_retain",     32'(bus.card_retain),     32'(e_retain));
        chk("session_active",  32'(bus.session_active),  32'(e_active));
        chk("err",             32'(bus.err),             32'(e_err));
        chk("updated_balance", 32'(bus.updated_balance), 32'(e_upd));
        if (e_disp) chk("dispense_amount", 32'(bus.dispense_amount), 32'(e_damt));
    end

    task automatic tick();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic insert(input longint b);
        bus.card_in = 1'b0;
        tick();
        bus.balance = BW'(b);
        bus.card_in = 1'b1;
        tick();
    endtask

    task automatic pin(input bit wrong);
        bus.psw_en = 1'b1; bus.wrong_psw = wrong;
        tick();
        bus.psw_en = 1'b0; bus.wrong_psw = 1'b0;
    endtask

    task automatic do_op(input int sel, input longint amt);
        bus.op_valid = 1'b1; bus.op_sel = 2'(sel); bus.amount = BW'(amt);
        tick();
        bus.op_valid = 1'b0;
    endtask

    function automatic logic [BW-1:0] pick_bal();
        case ($urandom_range(0, 9))
            0:       return BW'($urandom_range(1048000, 1048575));
            1:       return BW'($urandom_range(0, 100));
            default: return BW'($urandom_range(0, 10000));
        endcase
    endfunction

    function automatic logic [BW-1:0] pick_amt();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return BW'($urandom_range(500000, 1048575));
            default: return BW'($urandom_range(1, 3000));
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.card_in = 0; bus.psw_en = 0; bus.wrong_psw = 0; bus.balance = '0;
        bus.op_valid = 0; bus.op_sel = '0; bus.amount = '0;
        model_reset();
        @(negedge clk); #1;
        chk("rst_session_active", 32'(bus.session_active),  32'd0);
        chk("rst_updated_bal",    32'(bus.updated_balance), 32'd0);
        chk("rst_err",            32'(bus.err),             32'd0);
        chk("rst_op_done",        32'(bus.op_done),         32'd0);
        chk("rst_dispense_amt",   32'(bus.dispense_amount), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Good PIN, withdraw 300 from 1000, then eject
        insert(1000); pin(0);
        do_op(1, 300); tick();
        chk("wd300_op_done",  32'(bus.op_done),         32'd1);
        chk("wd300_upd",      32'(bus.updated_balance), 32'd700);
        chk("wd300_dispense", 32'(bus.dispense),        32'd1);
        chk("wd300_damt",     32'(bus.dispense_amount), 32'd300);
        chk("wd300_err",      32'(bus.err),             32'd0);
        chk("wd300_model",    32'(e_upd),               32'd700);
        tick();
        do_op(3, 0);
        chk("eject_pulse", 32'(bus.card_eject), 32'd1);
        tick();
        chk("eject_idle", 32'(bus.session_active), 32'd0);

        // Three wrong PINs
        insert(500);
        pin(1); chk("pin1_err", 32'(bus.err), 32'd4);
        pin(1); chk("pin2_err", 32'(bus.err), 32'd4);
        pin(1);
        chk("pin3_retain", 32'(bus.card_retain), 32'd1);
        chk("pin3_err",    32'(bus.err),         32'd5);
        tick();
        chk("retain_idle",     32'(bus.session_active), 32'd0);
        chk("retain_err_held", 32'(bus.err),            32'd5);

        // Session limit and insufficient funds
        insert(6000); pin(0);
        do_op(1, 3000); tick();
        chk("wd3000_upd", 32'(bus.updated_balance), 32'd3000);
        tick();
        do_op(1, 2500); tick();
        chk("limit_err",      32'(bus.err),             32'd2);
        chk("limit_upd",      32'(bus.updated_balance), 32'd3000);
        chk("limit_dispense", 32'(bus.dispense),        32'd0);
        tick();
        insert(1000); pin(0);
        do_op(1, 7000); tick();
        chk("funds_err", 32'(bus.err),             32'd1);
        chk("funds_upd", 32'(bus.updated_balance), 32'd1000);
        tick();

        // Deposit overflow, zero deposit, then MENU timeout
        insert(BMAX - 4); pin(0);
        do_op(2, 10); tick();
        chk("ovf_err", 32'(bus.err),             32'd3);
        chk("ovf_upd", 32'(bus.updated_balance), 32'd1048571);
        tick();
        do_op(2, 0); tick();
        chk("dep0_done",     32'(bus.op_done),         32'd1);
        chk("dep0_err",      32'(bus.err),             32'd0);
        chk("dep0_upd",      32'(bus.updated_balance), 32'd1048571);
        chk("dep0_dispense", 32'(bus.dispense),        32'd0);
        tick();
        repeat (TO - 1) tick();
        chk("pre_timeout", 32'(bus.card_eject), 32'd0);
        tick();
        chk("timeout_eject", 32'(bus.card_eject), 32'd1);
        chk("timeout_err",   32'(bus.err),        32'd6);
        tick();

        // Card pulled during EXEC
        insert(1000); pin(0);
        do_op(1, 100);
        bus.card_in = 1'b0;
        tick();
        chk("drop_op_done", 32'(bus.op_done),        32'd0);
        chk("drop_active",  32'(bus.session_active), 32'd0);
        tick();
        chk("drop_dispense", 32'(bus.dispense),        32'd0);
        chk("drop_upd_held", 32'(bus.updated_balance), 32'd1048571);

        // Asynchronous reset during a withdraw
        insert(1000); pin(0);
        do_op(1, 200);
        #2 rst = 1'b1;
        #1;
        chk("arst_op_done",  32'(bus.op_done),         32'd0);
        chk("arst_dispense", 32'(bus.dispense),        32'd0);
        chk("arst_upd",      32'(bus.updated_balance), 32'd0);
        chk("arst_active",   32'(bus.session_active),  32'd0);
        chk("arst_eject",    32'(bus.card_eject),      32'd0);
        model_reset();
        bus.card_in = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("arst_no_commit", 32'(bus.updated_balance), 32'd0);

        // Randomized sessions
        for (int c = 0; c < 4000; c++) begin
            if (bus.card_in) begin
                if ($urandom_range(0, 99) == 0) bus.card_in = 1'b0;
            end else begin
                bus.balance = pick_bal();
                if ($urandom_range(0, 3) == 0) bus.card_in = 1'b1;
            end
            bus.psw_en    = ($urandom_range(0, 3) == 0);
            bus.wrong_psw = ($urandom_range(0, 2) == 0);
            bus.op_valid  = ($urandom_range(0, 2) == 0);
            bus.op_sel    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            bus.amount    = pick_amt();
            tick();
        end
        bus.psw_en = 0; bus.op_valid = 0; bus.card_in = 0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
